// File: rtl/triangle_streamer.sv
// Streams a stored triangle list to a block rasterizer once per screen block, in raster order.
// The triangle list lives in a synchronous RAM; outputs are fully registered.
module triangle_streamer #(
  parameter int unsigned MAX_TRIS   = 64,
  parameter int unsigned BLOCK_SIZE = 16,
  parameter int unsigned SCREEN_W   = 640,
  parameter int unsigned SCREEN_H   = 480
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        ld,
  input  logic [15:0]                 ld_color,
  input  logic [17:0]                 ld_d1,
  input  logic [17:0]                 ld_d2,
  input  logic [17:0]                 ld_d3,
  input  logic [1:0][17:0]            ld_vert1,
  input  logic [1:0][17:0]            ld_vert2,
  input  logic [1:0][17:0]            ld_vert3,
  input  logic                        clear,
  input  logic                        start,
  input  logic                        ready,
  output logic                        data_in,
  output logic [15:0]                 color,
  output logic [17:0]                 d1,
  output logic [17:0]                 d2,
  output logic [17:0]                 d3,
  output logic [1:0][17:0]            vert1,
  output logic [1:0][17:0]            vert2,
  output logic [1:0][17:0]            vert3,
  output logic [1:0][9:0]             block_location,
  output logic [$clog2(MAX_TRIS):0]   tri_count,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned IdxW = $clog2(MAX_TRIS);
  localparam int unsigned CntW = IdxW + 1;
  localparam logic [9:0] Step = 10'(BLOCK_SIZE);
  localparam logic [9:0] LastX = 10'(SCREEN_W - BLOCK_SIZE);
  localparam logic [9:0] LastY = 10'(SCREEN_H - BLOCK_SIZE);
  localparam logic [CntW-1:0] Full = CntW'(MAX_TRIS);

  typedef struct packed {
    logic [15:0]       color;
    logic [17:0]       d1;
    logic [17:0]       d2;
    logic [17:0]       d3;
    logic [1:0][17:0]  v1;
    logic [1:0][17:0]  v2;
    logic [1:0][17:0]  v3;
  } tri_t;

  typedef enum logic [2:0] {StIdle, StWait, StStream, StGap, StArm, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] rd_addr_q, rd_addr_d;
  logic [1:0][9:0] loc_q, loc_d;
  logic            rd_en, wr_en;
  logic [IdxW-1:0] rd_idx;
  logic            vld_q, data_in_q, busy_q, done_q;
  tri_t            wr_data, rd_data_q, out_q;
  tri_t            mem [MAX_TRIS];

  assign wr_data = {ld_color, ld_d1, ld_d2, ld_d3, ld_vert1, ld_vert2, ld_vert3};

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rd_addr_d = rd_addr_q;
    loc_d     = loc_q;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    rd_idx    = '0;
    unique case (state_q)
      StIdle: begin
        if (clear) begin
          count_d = '0;
        end else if (ld && count_q != Full) begin
          wr_en   = 1'b1;
          count_d = count_q + 1'b1;
        end
        // Judge emptiness on the updated length so clear/ld in the start cycle stay coherent.
        if (start) begin
          if (count_d == '0) begin
            state_d = StDone;
          end else begin
            state_d = StWait;
            loc_d   = '0;
          end
        end
      end
      StWait: begin
        if (ready) begin
          rd_en     = 1'b1;
          rd_addr_d = CntW'(1);
          state_d   = StStream;
        end
      end
      StStream: begin
        // Full-width compare lets a full list reach index MAX_TRIS-1 without wrapping.
        if (rd_addr_q < count_q) begin
          rd_en     = 1'b1;
          rd_idx    = rd_addr_q[IdxW-1:0];
          rd_addr_d = rd_addr_q + 1'b1;
        end
        if (!vld_q) begin
          state_d = StGap;
        end
      end
      StGap: begin
        if (loc_q[1] == LastX && loc_q[0] == LastY) begin
          state_d = StDone;
        end else begin
          if (loc_q[1] == LastX) begin
            loc_d[1] = '0;
            loc_d[0] = loc_q[0] + Step;
          end else begin
            loc_d[1] = loc_q[1] + Step;
          end
          state_d = StArm;
        end
      end
      StArm: begin
        if (!ready) begin
          state_d = StWait;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[count_q[IdxW-1:0]] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_idx];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      count_q   <= '0;
      rd_addr_q <= '0;
      loc_q     <= '0;
      vld_q     <= 1'b0;
      data_in_q <= 1'b0;
      out_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rd_addr_q <= rd_addr_d;
      loc_q     <= loc_d;
      vld_q     <= rd_en;
      data_in_q <= vld_q;
      if (vld_q) begin
        out_q <= rd_data_q;
      end
      busy_q    <= (state_d != StIdle) && (state_d != StDone);
      done_q    <= (state_d == StDone);
    end
  end

  assign data_in        = data_in_q;
  assign color          = out_q.color;
  assign d1             = out_q.d1;
  assign d2             = out_q.d2;
  assign d3             = out_q.d3;
  assign vert1          = out_q.v1;
  assign vert2          = out_q.v2;
  assign vert3          = out_q.v3;
  assign block_location = loc_q;
  assign tri_count      = count_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_triangle_streamer.sv
// Randomized bench for triangle_streamer on a 32x32 screen of 16-pixel blocks, 8-entry list.
// Expected bursts come from a queue of loaded triangles and the raster-order block walk.
module tb_triangle_streamer;

  localparam int unsigned MaxTris = 8;
  localparam int unsigned Bs      = 16;
  localparam int unsigned ScrW    = 32;
  localparam int unsigned ScrH    = 32;
  localparam int          NBlk    = (ScrW / Bs) * (ScrH / Bs);
  localparam int          TriW    = 178;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             ld = 1'b0, clear = 1'b0, start = 1'b0, ready = 1'b0;
  logic [15:0]      ld_color = '0;
  logic [17:0]      ld_d1 = '0, ld_d2 = '0, ld_d3 = '0;
  logic [1:0][17:0] ld_vert1 = '0, ld_vert2 = '0, ld_vert3 = '0;
  logic             data_in, busy, done;
  logic [15:0]      color;
  logic [17:0]      d1, d2, d3;
  logic [1:0][17:0] vert1, vert2, vert3;
  logic [1:0][9:0]  block_location;
  logic [3:0]       tri_count;

  logic [TriW-1:0]  out_tri;
  logic [TriW-1:0]  model_q[$];
  int               n_err = 0;
  int               n_chk = 0;

  triangle_streamer #(
    .MAX_TRIS  (MaxTris),
    .BLOCK_SIZE(Bs),
    .SCREEN_W  (ScrW),
    .SCREEN_H  (ScrH)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .ld            (ld),
    .ld_color      (ld_color),
    .ld_d1         (ld_d1),
    .ld_d2         (ld_d2),
    .ld_d3         (ld_d3),
    .ld_vert1      (ld_vert1),
    .ld_vert2      (ld_vert2),
    .ld_vert3      (ld_vert3),
    .clear         (clear),
    .start         (start),
    .ready         (ready),
    .data_in       (data_in),
    .color         (color),
    .d1            (d1),
    .d2            (d2),
    .d3            (d3),
    .vert1         (vert1),
    .vert2         (vert2),
    .vert3         (vert3),
    .block_location(block_location),
    .tri_count     (tri_count),
    .busy          (busy),
    .done          (done)
  );

  always #5 clock = ~clock;

  assign out_tri = {color, d1, d2, d3, vert1, vert2, vert3};

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [TriW-1:0] rand_tri();
    logic [191:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return r[TriW-1:0];
  endfunction

  task automatic load_tri(input logic [TriW-1:0] t);
    ld = 1'b1;
    {ld_color, ld_d1, ld_d2, ld_d3, ld_vert1, ld_vert2, ld_vert3} = t;
    @(negedge clock);
    ld = 1'b0;
    if (model_q.size() < MaxTris) model_q.push_back(t);
  endtask

  task automatic clear_list();
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    model_q.delete();
  endtask

  // One full pass; the bench plays the rasterizer, dropping ready once a burst begins.
  task automatic run_pass(input int hold_low, input bit poke);
    int k, w, g;
    logic [3:0]      exp_cnt;
    logic [1:0][9:0] exp_loc;
    exp_cnt = 4'(model_q.size());
    ready = 1'b0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n_chk++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL busy_after_start: got %b want 1", busy); end
    if (poke) begin
      ld = 1'b1; clear = 1'b1; start = 1'b1;
      {ld_color, ld_d1, ld_d2, ld_d3, ld_vert1, ld_vert2, ld_vert3} = rand_tri();
      @(negedge clock);
      ld = 1'b0; clear = 1'b0; start = 1'b0;
      n_chk++;
      if (tri_count !== exp_cnt) begin
        n_err++; $display("FAIL busy_ignore_cnt: got %0d want %0d", tri_count, exp_cnt);
      end
    end
    repeat ($urandom_range(0, 3)) @(negedge clock);
    for (int b = 0; b < NBlk; b++) begin
      exp_loc[1] = 10'((b % (ScrW / Bs)) * Bs);
      exp_loc[0] = 10'((b / (ScrW / Bs)) * Bs);
      ready = 1'b1;
      @(negedge clock);
      n_chk++;
      if (data_in !== 1'b0) begin n_err++; $display("FAIL lat_early blk%0d: got %b want 0", b, data_in); end
      @(negedge clock);
      n_chk++;
      if (data_in !== 1'b1) begin n_err++; $display("FAIL lat_n2 blk%0d: got %b want 1", b, data_in); end
      w = 0;
      while (data_in !== 1'b1 && w < 20) begin @(negedge clock); w++; end
      if (data_in !== 1'b1) begin
        n_chk++; n_err++;
        $display("FAIL burst_timeout blk%0d: got no data_in want burst", b);
        ready = 1'b0;
        return;
      end
      ready = 1'b0;
      k = 0;
      while (data_in === 1'b1 && k < MaxTris + 2) begin
        n_chk++;
        if (k >= model_q.size()) begin
          n_err++; $display("FAIL extra_entry blk%0d idx%0d: got %0h want none", b, k, out_tri);
        end else if (out_tri !== model_q[k]) begin
          n_err++; $display("FAIL entry blk%0d idx%0d: got %0h want %0h", b, k, out_tri, model_q[k]);
        end
        n_chk++;
        if (block_location !== exp_loc) begin
          n_err++; $display("FAIL loc blk%0d: got %0h want %0h", b, block_location, exp_loc);
        end
        k++;
        @(negedge clock);
      end
      n_chk++;
      if (k != model_q.size()) begin
        n_err++; $display("FAIL burst_len blk%0d: got %0d want %0d", b, k, model_q.size());
      end
      if (b == NBlk - 1) begin
        n_chk++;
        if (done !== 1'b0 || busy !== 1'b1) begin
          n_err++; $display("FAIL gap_flags: got done=%b busy=%b want 0,1", done, busy);
        end
        @(negedge clock);
        n_chk++;
        if (done !== 1'b1 || busy !== 1'b0) begin
          n_err++; $display("FAIL done_pulse: got done=%b busy=%b want 1,0", done, busy);
        end
        @(negedge clock);
        n_chk++;
        if (done !== 1'b0 || busy !== 1'b0) begin
          n_err++; $display("FAIL done_once: got done=%b busy=%b want 0,0", done, busy);
        end
      end else begin
        g = (b == 0 && hold_low > 0) ? hold_low : 2 + $urandom_range(0, 3);
        repeat (g) begin
          @(negedge clock);
          n_chk++;
          if (data_in !== 1'b0) begin
            n_err++; $display("FAIL ready_low_quiet blk%0d: got %b want 0", b, data_in);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    n_chk += 6;
    if (data_in !== 1'b0) begin n_err++; $display("FAIL rst_data_in: got %b want 0", data_in); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", done); end
    if (tri_count !== 4'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", tri_count); end
    if (out_tri !== '0) begin n_err++; $display("FAIL rst_fields: got %0h want 0", out_tri); end
    if (block_location !== '0) begin
      n_err++; $display("FAIL rst_loc: got %0h want 0", block_location);
    end
  endtask

  task automatic test_basic();
    logic [TriW-1:0] t;
    int dep[4] = '{31, 27, 28, 30};
    for (int i = 0; i < 4; i++) begin
      t = {16'(i), 18'(dep[i] << 12), 18'(dep[(i + 1) % 4] << 12), 18'(dep[(i + 2) % 4] << 12),
           18'd50, 18'd40, 18'd40, 18'd60, 18'd60, 18'd60};
      load_tri(t);
    end
    n_chk++;
    if (tri_count !== 4'd4) begin n_err++; $display("FAIL basic_count: got %0d want 4", tri_count); end
    run_pass(0, 1'b0);
  endtask

  task automatic test_ready_hold();
    run_pass(50, 1'b0);
  endtask

  task automatic test_single();
    clear_list();
    load_tri(rand_tri());
    n_chk++;
    if (tri_count !== 4'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", tri_count); end
    run_pass(0, 1'b0);
  endtask

  task automatic test_random();
    int n;
    repeat (2) begin
      clear_list();
      n = $urandom_range(2, MaxTris);
      repeat (n) load_tri(rand_tri());
      run_pass(0, 1'b0);
    end
  endtask

  task automatic test_empty_start();
    int seen_done;
    clear_list();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 3; i++) begin
      if (done === 1'b1) seen_done++;
      n_chk++;
      if (data_in !== 1'b0) begin n_err++; $display("FAIL empty_data_in: got %b want 0", data_in); end
      @(negedge clock);
    end
    n_chk++;
    if (seen_done != 1) begin n_err++; $display("FAIL empty_done: got %0d pulses want 1", seen_done); end
  endtask

  task automatic test_saturate();
    clear_list();
    repeat (MaxTris + 3) load_tri(rand_tri());
    n_chk++;
    if (tri_count !== 4'(MaxTris)) begin
      n_err++; $display("FAIL sat_count: got %0d want %0d", tri_count, MaxTris);
    end
    run_pass(0, 1'b0);
  endtask

  task automatic test_busy_ignore();
    clear_list();
    repeat (3) load_tri(rand_tri());
    run_pass(0, 1'b1);
    clear = 1'b1;
    ld = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    ld = 1'b0;
    model_q.delete();
    n_chk++;
    if (tri_count !== 4'd0) begin n_err++; $display("FAIL clear_prio: got %0d want 0", tri_count); end
  endtask

  task automatic test_reset_mid();
    int w;
    clear_list();
    repeat (3) load_tri(rand_tri());
    ready = 1'b0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    ready = 1'b1;
    w = 0;
    while (data_in !== 1'b1 && w < 20) begin @(negedge clock); w++; end
    ready = 1'b0;
    w = 0;
    while (data_in === 1'b1 && w < 20) begin @(negedge clock); w++; end
    repeat (3) @(negedge clock);
    ready = 1'b1;
    w = 0;
    while (data_in !== 1'b1 && w < 20) begin @(negedge clock); w++; end
    n_chk++;
    if (data_in !== 1'b1 || block_location !== {10'd16, 10'd0}) begin
      n_err++;
      $display("FAIL mid_setup: got data_in=%b loc=%0h want 1,%0h", data_in, block_location,
               {10'd16, 10'd0});
    end
    #2 reset_n = 1'b0;
    #1;
    n_chk += 4;
    if (data_in !== 1'b0) begin n_err++; $display("FAIL async_data_in: got %b want 0", data_in); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL async_busy: got %b want 0", busy); end
    if (block_location !== '0) begin
      n_err++; $display("FAIL async_loc: got %0h want 0", block_location);
    end
    if (tri_count !== 4'd0) begin n_err++; $display("FAIL async_count: got %0d want 0", tri_count); end
    ready = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    model_q.delete();
    @(negedge clock);
    repeat (2) load_tri(rand_tri());
    run_pass(0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ready_hold();
    test_single();
    test_random();
    test_empty_start();
    test_saturate();
    test_busy_ignore();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/triangle_streamer.md
# triangle_streamer

Drives the triangle-input side of a block rasterizer. Triangles are loaded once into an internal list. On `start`, the block walks every screen block in raster order. For each block it waits until the rasterizer signals ready, presents the block's top-left corner, and streams the whole list back-to-back with `data_in` high. Its outputs keep the rasterizer's input port names so the two connect directly.

## Interface
Parameters:
- MAX_TRIS, 64, capacity of the triangle list (power of two).
- BLOCK_SIZE, 16, block edge in pixels (power of two).
- SCREEN_W, 640, screen width in pixels (multiple of BLOCK_SIZE).
- SCREEN_H, 480, screen height in pixels (multiple of BLOCK_SIZE).

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ld  in  1  append one triangle to the list this cycle.
- ld_color  in  16  RGB565 colour of the triangle being loaded.
- ld_d1, ld_d2, ld_d3  in  18 each  vertex depths, Q6.12.
- ld_vert1, ld_vert2, ld_vert3  in  [1:0] x 18  vertices, Q18.0; index 1 = x, index 0 = y.
- clear  in  1  empty the list.
- start  in  1  begin one full-screen pass.
- ready  in  1  rasterizer can accept a new triangle stream.
- data_in  out  1  triangle fields valid this cycle.
- color  out  16  current triangle colour.
- d1, d2, d3  out  18 each  current triangle depths.
- vert1, vert2, vert3  out  [1:0] x 18  current triangle vertices.
- block_location  out  [1:0] x 10  top-left corner of the current block, Q10.0; index 1 = x, index 0 = y.
- tri_count  out  $clog2(MAX_TRIS)+1  number of triangles in the list.
- busy  out  1  a pass is in progress.
- done  out  1  one-cycle pulse when a pass completes.

## Operation
- Triangle list: synchronous RAM, MAX_TRIS entries of 16+3*18+6*18 bits, one read per cycle.
- Loading (IDLE only):
  - `ld` writes the entry at index `tri_count`, then increments `tri_count`.
  - `ld` is ignored when `tri_count == MAX_TRIS`.
  - `clear` sets `tri_count` to 0 and has priority over `ld` in the same cycle.
  - `ld`, `clear` and `start` are ignored while `busy` is high.
- States:
  - IDLE: `start` with `tri_count == 0` → DONE. `start` otherwise → WAIT; block_location is set to (0,0).
  - WAIT: sampling `ready == 1` moves to STREAM and issues a read of entry 0.
  - STREAM: drives one triangle per cycle. After the last index has been driven → GAP.
  - GAP: one cycle with `data_in = 0`. Then:
    - If the block was the last one → DONE.
    - Otherwise block_location advances (x += BLOCK_SIZE; on reaching SCREEN_W, x = 0 and y += BLOCK_SIZE) → ARM.
  - ARM: waits for `ready == 0` → WAIT. This makes the next stream wait for a fresh rising edge of `ready`.
  - DONE: pulses `done` for one cycle → IDLE.
- Triangle order within a block is list order, index 0 first. Every block receives the identical sequence.
- block_location holds its value from entry to WAIT until the following GAP.
- Outputs are registered. Triangle fields hold their last values when `data_in = 0`.
- `ready` is sampled only in WAIT and ARM. Deassertion of `ready` during STREAM does not pause the stream.

## Timing
- Reset values:
  - data_in = 0, busy = 0, done = 0, tri_count = 0.
  - color, d1..d3, vert1..vert3 = 0; block_location = (0,0).
  - state = IDLE.
- RAM contents are not reset.
- `start` sampled in cycle N: `busy = 1` from N+1.
- `ready` sampled high in WAIT at cycle N: `data_in = 1` with entry 0 at cycle N+2 (one cycle RAM latency plus output register).
- Streaming is gapless: entry k appears at cycle N+2+k. `data_in` is high for exactly `tri_count` consecutive cycles.
- `tri_count == 1`: a single-cycle `data_in` pulse per block.
- `tri_count == MAX_TRIS`: all entries are streamed. The read index must not wrap to 0 early.
- Last block is (SCREEN_W-BLOCK_SIZE, SCREEN_H-BLOCK_SIZE). `done` asserts the cycle after its GAP; `busy` falls in the same cycle.
- Asynchronous reset mid-pass: all outputs return to reset values immediately and the list length becomes 0.

## Test plan
- Load 4 triangles (colours 0,1,2,3; depths 31,27,28,30 in Q6.12; vertices (50,40),(40,60),(60,60)) with SCREEN 32x32, BLOCK_SIZE 16, `ready` tied high after a delay. Then `start` → four bursts of exactly 4 `data_in` cycles with colours 0,1,2,3. block_location sequence (0,0),(16,0),(0,16),(16,16). One `done` pulse.
- Hold `ready` low for 50 cycles after the first burst, then raise it → no `data_in` during the low period. Second burst starts 2 cycles after `ready` is sampled high.
- `start` with an empty list → `done` pulses within 3 cycles; `data_in` never asserts.
- Load MAX_TRIS+3 triangles → `tri_count` saturates at MAX_TRIS. Each burst is exactly MAX_TRIS cycles long, entry 0 first and entry MAX_TRIS-1 last.
- Assert `ld`/`start` while busy, and `clear` with `ld` in the same cycle while idle → busy-time requests ignored; `tri_count` becomes 0.
- Drop `reset_n` mid-burst → `data_in`, `busy` and `block_location` go to 0 without waiting for a clock edge. A fresh load plus `start` then works normally.
